ws_pe_row: RTL and testbench



---
 rtl/ws_pkg.sv | 30 +++
 rtl/ws_pe_row_if.sv | 30 +++
 rtl/ws_dot.sv | 27 ++
 rtl/ws_pe_row.sv | 165 ++++++++++++++++
 tb/tb_ws_pe_row.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ws_pkg.sv
// Shared types and constants for the weight-stationary PE row.
//   ACT_W / W_W : activation and weight widths (signed)
//   PROD_W      : full-precision width of one weight*activation product
//   CNT_W       : width of the per-row activation counters (matches num_act)
//   state_t     : row sequencing states
//   clog2       : ceiling log2 helper for sizing accumulators
package ws_pkg;

    localparam int unsigned ACT_W  = 8;
    localparam int unsigned W_W    = 8;
    localparam int unsigned PROD_W = ACT_W + W_W;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ws_pe_row_if.sv
// Bus bundle between the activation buffer / controller and one PE row.
//   slave  : the PE row (consumes weights, start, act_in; drives act_rd and results)
//   master : the environment driving the PE row
interface ws_pe_row_if #(
    parameter int unsigned ACC_W = 20
);
    import ws_pkg::*;

    logic                     w_load;
    logic signed [W_W-1:0]    w_in;
    logic                     start;
    logic [CNT_W-1:0]         num_act;
    logic                     act_rd;
    logic signed [ACT_W-1:0]  act_in;
    logic signed [ACC_W-1:0]  psum_out;
    logic                     psum_valid;
    logic                     busy;
    logic                     done;

    modport slave (
        input  w_load, w_in, start, num_act, act_in,
        output act_rd, psum_out, psum_valid, busy, done
    );

    modport master (
        output w_load, w_in, start, num_act, act_in,
        input  act_rd, psum_out, psum_valid, busy, done
    );

endinterface

// File: rtl/ws_dot.sv
// Combinational signed dot product of KSIZE weights and KSIZE activations.
//   w     : weights, signed W_W bits each
//   a     : window samples, signed ACT_W bits each
//   dot_c : sum of sign-extended 16-bit products, ACC_W bits, wraps (no saturation)
module ws_dot
    import ws_pkg::*;
#(
    parameter int unsigned KSIZE = 3,
    parameter int unsigned ACC_W = 20
) (
    input  logic signed [W_W-1:0]   w [KSIZE],
    input  logic signed [ACT_W-1:0] a [KSIZE],
    output logic signed [ACC_W-1:0] dot_c
);

    logic signed [PROD_W-1:0] prod;

    always_comb begin
        dot_c = '0;
        prod  = '0;
        for (int i = 0; i < int'(KSIZE); i++) begin
            prod  = PROD_W'(w[i]) * PROD_W'(a[i]);
            dot_c = dot_c + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/ws_pe_row.sv
// Weight-stationary PE for one convolution row.
//   sys_clk, rst_n : clock and asynchronous active-low reset
//   bus (slave)    : weight load, row start/num_act, activation read request and
//                    returned data, registered psum result/valid, busy and done
// Weights shift in while idle; a row streams num_act reads, slides a KSIZE window
// and emits one psum per full window, three cycles after the read that completes it.
module ws_pe_row
    import ws_pkg::*;
#(
    parameter int unsigned KSIZE = 3,
    parameter int unsigned ACC_W = 20
) (
    input logic       sys_clk,
    input logic       rst_n,
    ws_pe_row_if.slave bus
);

    state_t                  state, state_d;
    logic [CNT_W-1:0]        rd_cnt, rd_cnt_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic                    act_rd_q, act_rd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    row_start;
    logic                    w_shift;

    logic signed [W_W-1:0]   w_q   [KSIZE];
    logic signed [ACT_W-1:0] win_q [KSIZE];
    logic [CNT_W-1:0]        fill;
    logic                    rd_d1;      // act_in carries valid data this cycle
    logic                    win_vld;    // window is full and was just updated
    logic signed [ACC_W-1:0] psum_q;
    logic                    psum_valid_q;
    logic signed [ACC_W-1:0] dot_c;

    // FSM state and control output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            num_q    <= '0;
            act_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            rd_cnt   <= rd_cnt_d;
            num_q    <= num_d;
            act_rd_q <= act_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        rd_cnt_d  = rd_cnt;
        num_d     = num_q;
        act_rd_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        row_start = 1'b0;
        w_shift   = 1'b0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    row_start = 1'b1;
                    num_d     = bus.num_act;
                    busy_d    = 1'b1;
                    if (bus.num_act >= CNT_W'(KSIZE)) begin
                        state_d  = RUN;
                        act_rd_d = 1'b1;
                        rd_cnt_d = CNT_W'(1);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (bus.w_load) begin
                    w_shift = 1'b1;
                end
            end
            RUN: begin
                if (rd_cnt == num_q) begin
                    state_d = DRAIN;
                end else begin
                    act_rd_d = 1'b1;
                    rd_cnt_d = rd_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                // last psum is on the output and nothing is left in the pipe
                if (psum_valid_q && !win_vld && !rd_d1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Weight shift register, activation window and psum output register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(KSIZE); i++) begin
                w_q[i]   <= '0;
                win_q[i] <= '0;
            end
            fill         <= '0;
            rd_d1        <= 1'b0;
            win_vld      <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            rd_d1        <= act_rd_q;
            psum_valid_q <= win_vld;
            if (win_vld) begin
                psum_q <= dot_c;
            end
            if (w_shift) begin
                for (int i = 0; i < int'(KSIZE) - 1; i++) begin
                    w_q[i] <= w_q[i+1];
                end
                w_q[KSIZE-1] <= bus.w_in;
            end
            if (row_start) begin
                for (int i = 0; i < int'(KSIZE); i++) begin
                    win_q[i] <= '0;
                end
                fill    <= '0;
                win_vld <= 1'b0;
            end else begin
                win_vld <= rd_d1 && (fill >= CNT_W'(KSIZE - 1));
                if (rd_d1) begin
                    for (int i = 0; i < int'(KSIZE) - 1; i++) begin
                        win_q[i] <= win_q[i+1];
                    end
                    win_q[KSIZE-1] <= bus.act_in;
                    fill           <= fill + CNT_W'(1);
                end
            end
        end
    end

    ws_dot #(
        .KSIZE (KSIZE),
        .ACC_W (ACC_W)
    ) u_dot (
        .w     (w_q),
        .a     (win_q),
        .dot_c (dot_c)
    );

    assign bus.act_rd     = act_rd_q;
    assign bus.psum_out   = psum_q;
    assign bus.psum_valid = psum_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_ws_pe_row.sv
// Directed bench for ws_pe_row (KSIZE=3, ACC_W=20). Inputs change at negedge or
// just after posedge; outputs are sampled at negedge. A small buffer model returns
// the next queued activation the cycle after each observed act_rd.
module tb_ws_pe_row;

    logic sys_clk;
    logic rst_n;

    ws_pe_row_if #(.ACC_W(20)) bus ();

    ws_pe_row #(
        .KSIZE (3),
        .ACC_W (20)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    bit rd_seen = 1'b0;
    int act_q[$];
    int rd_n;
    int rd_cyc[$];
    int ps_val[$];
    int ps_cyc[$];
    int done_n;
    int done_cyc;
    int start_cyc;
    int first_busy;
    int after_busy;
    int timeout;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    // One clock: buffer model drives act_in after the edge, outputs sampled at negedge
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (rd_seen && act_q.size() > 0) bus.act_in = 8'(act_q.pop_front());
        else                             bus.act_in = 8'sh5A;
        @(negedge sys_clk);
        cyc++;
        rd_seen = bus.act_rd;
        if (bus.act_rd) begin
            rd_n++;
            rd_cyc.push_back(cyc);
        end
        if (bus.psum_valid) begin
            ps_val.push_back(int'(bus.psum_out));
            ps_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_n++;
            done_cyc = cyc;
        end
    endtask

    task automatic load_w(input int a, input int b, input int c);
        int v[3];
        v = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            bus.w_load = 1'b1;
            bus.w_in   = 8'(v[i]);
            tick();
        end
        bus.w_load = 1'b0;
    endtask

    // Runs one row; optionally w_load with start, and a w_load+start pulse at relative cycle inj
    task automatic run_row(input int num, input bit wl_with_start, input int inj);
        rd_n = 0; done_n = 0; done_cyc = -1;
        rd_cyc.delete(); ps_val.delete(); ps_cyc.delete();
        bus.num_act = 6'(num);
        bus.start   = 1'b1;
        if (wl_with_start) begin
            bus.w_load = 1'b1;
            bus.w_in   = 8'sd100;
        end
        tick();
        start_cyc  = cyc - 1;
        first_busy = int'(bus.busy);
        bus.start  = 1'b0;
        bus.w_load = 1'b0;
        for (int k = 2; k < 80 && !(done_n > 0 && cyc > done_cyc); k++) begin
            if (k == inj) begin
                bus.start  = 1'b1;
                bus.w_load = 1'b1;
                bus.w_in   = 8'sd9;
            end else begin
                bus.start  = 1'b0;
                bus.w_load = 1'b0;
            end
            tick();
        end
        bus.start  = 1'b0;
        bus.w_load = 1'b0;
        after_busy = int'(bus.busy);
        timeout    = (done_n == 0) ? 1 : 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.w_load  = 1'b0;
        bus.w_in    = '0;
        bus.start   = 1'b0;
        bus.num_act = '0;
        bus.act_in  = '0;
        repeat (2) @(negedge sys_clk);
        check("rst_act_rd", int'(bus.act_rd), 0);
        check("rst_psum_valid", int'(bus.psum_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_psum_out", int'(bus.psum_out), 0);
        rst_n = 1'b1;
        tick();

        // Row 1: weights 1,2,3; activations 1..4
        load_w(1, 2, 3);
        act_q = '{1, 2, 3, 4};
        run_row(4, 1'b0, 0);
        check("r1_timeout", timeout, 0);
        check("r1_busy_rise", first_busy, 1);
        check("r1_first_rd", qget(rd_cyc, 0), start_cyc + 1);
        check("r1_rd_count", rd_n, 4);
        check("r1_psum_count", ps_val.size(), 2);
        check("r1_psum0", qget(ps_val, 0), 14);
        check("r1_psum1", qget(ps_val, 1), 20);
        check("r1_psum0_lat", qget(ps_cyc, 0), qget(rd_cyc, 2) + 3);
        check("r1_psum1_b2b", qget(ps_cyc, 1), qget(ps_cyc, 0) + 1);
        check("r1_done_cyc", done_cyc, qget(ps_cyc, 1) + 1);
        check("r1_done_pulses", done_n, 1);
        check("r1_busy_fall", after_busy, 0);
        check("r1_psum_hold", int'(bus.psum_out), 20);

        // Row 2: same weights, w_load with start is ignored, window starts empty
        act_q = '{5, 0, -1};
        run_row(3, 1'b1, 0);
        check("r2_timeout", timeout, 0);
        check("r2_psum_count", ps_val.size(), 1);
        check("r2_psum0", qget(ps_val, 0), 2);
        check("r2_done_cyc", done_cyc, qget(ps_cyc, 0) + 1);

        // Extreme values: no overflow in a 20-bit accumulator
        load_w(-128, -128, -128);
        act_q = '{-128, -128, -128};
        run_row(3, 1'b0, 0);
        check("neg_timeout", timeout, 0);
        check("neg_psum_count", ps_val.size(), 1);
        check("neg_psum", qget(ps_val, 0), 49152);
        load_w(127, 127, 127);
        act_q = '{-128, -128, -128};
        run_row(3, 1'b0, 0);
        check("mix_psum_count", ps_val.size(), 1);
        check("mix_psum", qget(ps_val, 0), -48768);

        // Short row: no reads, no psums, done the cycle after start
        run_row(2, 1'b0, 0);
        check("short_timeout", timeout, 0);
        check("short_busy", first_busy, 1);
        check("short_rd", rd_n, 0);
        check("short_psum_count", ps_val.size(), 0);
        check("short_done_cyc", done_cyc, start_cyc + 1);
        check("short_busy_fall", after_busy, 0);

        // w_load and start during RUN are ignored
        load_w(1, 2, 3);
        act_q = '{1, 2, 3, 4};
        run_row(4, 1'b0, 2);
        check("inj_rd_count", rd_n, 4);
        check("inj_psum_count", ps_val.size(), 2);
        check("inj_psum0", qget(ps_val, 0), 14);
        check("inj_psum1", qget(ps_val, 1), 20);
        check("inj_done_pulses", done_n, 1);
        act_q = '{5, 0, -1};
        run_row(3, 1'b0, 0);
        check("inj_w_kept", qget(ps_val, 0), 2);

        // Asynchronous reset in the middle of a row
        act_q = '{1, 2, 3, 4, 5, 6};
        bus.num_act = 6'd6;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_rd", int'(bus.act_rd), 1);
        check("pre_rst_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_act_rd", int'(bus.act_rd), 0);
        check("mid_rst_psum_valid", int'(bus.psum_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_psum_out", int'(bus.psum_out), 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        rd_seen = 1'b0;
        act_q.delete();
        bus.act_in = '0;

        // Weights were cleared: a row without loading yields zero
        act_q = '{7, 7, 7};
        run_row(3, 1'b0, 0);
        check("post_rst_timeout", timeout, 0);
        check("post_rst_psum_count", ps_val.size(), 1);
        check("post_rst_w_zero", qget(ps_val, 0), 0);

        // Fresh load and row after reset
        load_w(2, -1, 1);
        act_q = '{3, 4, 5, 6};
        run_row(4, 1'b0, 0);
        check("fresh_psum_count", ps_val.size(), 2);
        check("fresh_psum0", qget(ps_val, 0), 7);
        check("fresh_psum1", qget(ps_val, 1), 9);
        check("fresh_done_cyc", done_cyc, qget(ps_cyc, 1) + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
